// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-state encoding, default bubble instruction and payload type for pipeline stages
package pipe_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stageState_t;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } payload_t;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: single valid+payload register with load/clear controls; clear wins over load
module pipe_skid_entry #(
    parameter int W = 64,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= RESET_VAL;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked PC+instruction stage register with 2-entry skid buffer and synchronous flush.
// Optional PIPE_STAGE_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int INSTR_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]        stall_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic [INSTR_W-1:0] out_instr
);
    localparam int W = PC_W + INSTR_W;
    stageState_t state, nextState;
    logic mainLoad, mainClear, skidLoad, skidClear, mainSel;
    logic mainValid, skidValid;
    logic [W-1:0] mainQ, skidQ;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_EMPTY;
        else        state <= nextState;
    always_comb begin
        nextState = state;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        mainSel   = 1'b0;
        if (flush) begin
            nextState = ST_EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: if (in_valid) begin
                    mainLoad  = 1'b1;
                    nextState = ST_FULL;
                end
                ST_FULL: if (out_ready && in_valid) begin
                    mainLoad = 1'b1;
                end else if (out_ready) begin
                    mainClear = 1'b1;
                    nextState = ST_EMPTY;
                end else if (in_valid) begin
                    skidLoad  = 1'b1;
                    nextState = ST_SKID;
                end
                ST_SKID: if (out_ready) begin
                    mainLoad  = 1'b1;
                    mainSel   = 1'b1;
                    skidClear = 1'b1;
                    nextState = ST_FULL;
                end
                default: nextState = ST_EMPTY;
            endcase
        end
    end
    pipe_skid_entry #(.W(W), .RESET_VAL({RESET_PC, NOP_INSTR})) mainEntry (
        .clk(clk), .rst_n(rst_n), .load(mainLoad), .clear(mainClear),
        .d(mainSel ? skidQ : {in_pc, in_instr}), .valid(mainValid), .q(mainQ)
    );
    pipe_skid_entry #(.W(W)) skidEntry (
        .clk(clk), .rst_n(rst_n), .load(skidLoad), .clear(skidClear),
        .d({in_pc, in_instr}), .valid(skidValid), .q(skidQ)
    );
    // in_ready comes straight off the skid valid flop, so it has no combinational input path
    assign in_ready  = !skidValid;
    assign out_valid = mainValid;
    assign out_pc    = mainQ[W-1:INSTR_W];
    assign out_instr = mainValid ? mainQ[INSTR_W-1:0] : NOP_INSTR;
`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (flush && out_valid && !(&flush_cnt))      flush_cnt <= flush_cnt + 16'd1;
        end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with a scoreboard queue checked by an output monitor
module tb_pipe_stage_reg;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif
    int checks = 0, errors = 0, popped = 0, expPop = 7;
    logic [63:0] expQ[$];
    logic [63:0] head;

    pipe_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = 32'hA000_0000 | pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Monitor: negedge sees the handshakes that complete at the following posedge
    always @(negedge clk) begin
        if (!rst_n) expQ.delete();
        else begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) chk("unexpected_output", out_pc, 32'hFFFF_FFFF);
                else begin
                    head = expQ.pop_front();
                    chk("sb_pc", out_pc, head[63:32]);
                    chk("sb_instr", out_instr, head[31:0]);
                    popped++;
                end
            end
            if (flush) expQ.delete();
            else if (in_valid && in_ready) expQ.push_back({in_pc, 32'hA000_0000 | in_pc});
        end
    end

    initial begin
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h13);
        rst_n = 1'b1;
        // streaming, one per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
            step();
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_pc", out_pc, 32'(4 * i));
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_nop", out_instr, 32'h13);
        // backpressure into skid
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        chk("bp_pc", out_pc, 32'h10);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        step();
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        step();
        chk("bp_hold_pc", out_pc, 32'h10);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("bp_skid_pc", out_pc, 32'h14);
        chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);
        // fill to SKID, then stability under random inputs
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h24, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), $urandom, 1'b0, 1'b0);
            step();
            chk("stable_pc", out_pc, 32'h20);
            chk("stable_instr", out_instr, 32'hA000_0020);
        end
        // flush in SKID with an offered input
        drive(1'b1, 32'h28, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_nop", out_instr, 32'h13);
        chk("flush_keep_pc", out_pc, 32'h20);
        step();
        chk("flush_no_28", {31'b0, out_valid}, 32'd0);
        // flush in FULL with consumer handshake in the same cycle
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h34, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
        step();
        // asynchronous reset mid-cycle with payload held
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_instr", out_instr, 32'h13);
        chk("async_rst_pc", out_pc, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_STAGE_STATS_EN
        expPop = 9;
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) step();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h54, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_cnt", stall_cnt, 32'd5);
        chk("flush_cnt", {16'b0, flush_cnt}, 32'd2);
        drive(1'b1, 32'h58, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        step();
        chk("stall_sat", stall_cnt, 32'hFFFF_FFFF);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
`endif
        step();
        chk("sb_drained", 32'(expQ.size()), 32'd0);
        chk("sb_pop_count", 32'(popped), 32'(expPop));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register that succeeds the fixed IF/ID register pair.
- Carries a PC + instruction payload between any two core stages using valid/ready flow control.
- A 2-entry skid buffer sustains full throughput while in_ready stays a registered signal.
- Synchronous flush squashes in-flight instructions, e.g. on a branch mispredict.

Parameters:
- PC_W, 32, PC field width.
- INSTR_W, 32, instruction field width.
- RESET_PC, 0, value driven on out_pc while empty after reset.
- NOP_INSTR, 32'h00000013, instruction driven on out_instr whenever out_valid=0 (RISC-V addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload; registered.
- in_pc  in  PC_W  upstream PC.
- in_instr  in  INSTR_W  upstream instruction.
- out_valid  out  1  out_pc/out_instr are valid.
- out_ready  in  1  downstream consumes this cycle.
- out_pc  out  PC_W  held PC.
- out_instr  out  INSTR_W  held instruction, or NOP_INSTR when not valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, port name rst_n. While rst_n=0: state EMPTY, out_valid=0, in_ready=1, out_pc=RESET_PC, out_instr=NOP_INSTR, skid entry invalid. Reset may assert mid-transfer; all entries are dropped with no partial update.
- Transfer rules: an input transfer occurs when in_valid & in_ready at a clock edge; an output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid=1 (EMPTY path).
- Storage: main register (drives outputs) plus one skid register. in_ready = !skid_valid, registered.
- State EMPTY:
  - in_valid -> main<=in, go to FULL.
  - otherwise stay EMPTY.
- State FULL:
  - out_ready & in_valid -> main<=in, stay FULL (back-to-back throughput of 1 per cycle).
  - out_ready & !in_valid -> go to EMPTY.
  - !out_ready & in_valid -> skid<=in, go to SKID, in_ready<=0.
  - neither -> hold.
- State SKID:
  - in_ready=0; inputs are ignored.
  - out_ready -> main<=skid, go to FULL, in_ready<=1.
  - otherwise hold.
- Stability: while out_valid=1 and out_ready=0, out_pc and out_instr must not change.
- Ordering: strict FIFO; payloads are never reordered, duplicated or dropped except by flush or reset.
- Flush (priority over all handshakes): next state EMPTY, out_valid<=0, skid invalidated, in_ready<=1.
  - An input offered in the flush cycle is discarded even if in_ready=1.
  - A consumer handshake in the flush cycle still counts as a transfer.
  - out_pc keeps its last value and out_instr shows NOP_INSTR.
- Empty output: whenever out_valid=0, out_instr=NOP_INSTR, so a stage that ignores valid still sees a bubble.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt (32 bit) and flush_cnt (16 bit).
  - stall_cnt increments each cycle out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while out_valid=1.
  - Both saturate at all-ones and reset to 0 on rst_n.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - stage-state enum {ST_EMPTY, ST_FULL, ST_SKID};
  - the default NOP_INSTR constant;
  - a payload struct type {pc, instr}, reused by later ID/EX and EX/MEM instances.
- One natural sub-module, pipe_skid_entry: a single valid+payload register with load/clear controls. It is instantiated twice (main and skid).

Test Plan:
1. Reset: rst_n low mid-cycle with payload held -> out_valid=0 and out_instr=32'h00000013 immediately (asynchronous), in_ready=1 after rst_n rises.
2. Streaming: in_valid=1 for PCs 0x0,0x4,0x8,0xC with out_ready=1 -> out_pc shows 0x0..0xC on consecutive cycles, 1-cycle latency, in_ready stays 1.
3. Backpressure: out_ready=0 after PC 0x10 accepted, offer 0x14 -> skid captures 0x14, in_ready=0 next cycle. Release out_ready -> 0x10 then 0x14 delivered, no loss.
4. Flush in SKID: state SKID (0x20 main, 0x24 skid), flush=1 with in_valid=1 PC 0x28 -> next cycle out_valid=0, in_ready=1, out_instr=NOP, and 0x28 is never emitted.
5. Stability: hold out_ready=0 for 5 cycles with random inputs -> out_pc and out_instr unchanged.
6. Stats (PIPE_STAGE_STATS_EN): 5 stall cycles plus 2 flushes while valid -> stall_cnt=5, flush_cnt=2. Force stall_cnt to 32'hFFFFFFFF and stall once more -> it stays 32'hFFFFFFFF.
